// File: rtl/cnt_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_monitor_pkg                                                    |
// | Shared FSM encoding, event type codes and event word layout.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cnt_monitor_pkg;

    localparam int TYPE_W  = 2;
    localparam int SEQ_W   = 2;
    localparam int VALUE_W = 4;
    localparam int EV_W    = TYPE_W + SEQ_W + VALUE_W;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_INIT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_FAULT = 2'd2;

    localparam logic [TYPE_W-1:0] EV_WRAP     = 2'b01;
    localparam logic [TYPE_W-1:0] EV_STEP_ERR = 2'b10;

    function automatic logic [EV_W-1:0] pack_event(
        input logic [TYPE_W-1:0]  ev_type,
        input logic [SEQ_W-1:0]   ev_seq,
        input logic [VALUE_W-1:0] ev_value
    );
        return {ev_type, ev_seq, ev_value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_monitor_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_monitor_fifo                                                   |
// | Synchronous event FIFO; a push on a full buffer is accepted only   |
// | when a pop retires the head on the same edge.                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cnt_monitor_fifo
    import cnt_monitor_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_push_ok,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_push_ok = i_push && (!o_full || w_do_pop);
    // Head is masked while empty so stale storage never leaks out after reset.
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({o_push_ok, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (o_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/cnt_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_monitor                                                        |
// | Watches a 4-bit upstream counter, logs wraps (and step errors when |
// | CNT_MONITOR_STEP_CHECK_EN is defined) into an event FIFO.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cnt_monitor
    import cnt_monitor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] cnt_in,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [EV_W-1:0]    ev_data,
    output logic [7:0]         wrap_cnt,
    output logic               err,
    output logic               ev_overflow
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [VALUE_W-1:0] r_prev;
    logic [SEQ_W-1:0]   r_seq;
    logic [7:0]         r_wrap_cnt;
    logic               r_ovf;
    logic               w_wrap;
    logic               w_step_err;
    logic               w_push;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [TYPE_W-1:0]  w_ev_type;
    logic [EV_W-1:0]    w_ev_word;

    assign w_wrap = (r_state == ST_RUN) && (r_prev == {VALUE_W{1'b1}}) && (cnt_in == '0);

`ifdef CNT_MONITOR_STEP_CHECK_EN
    logic [VALUE_W-1:0] w_prev_inc;
    logic               r_err;

    assign w_prev_inc = r_prev + VALUE_W'(1);
    // A return to zero is an upstream reset, not an error.
    assign w_step_err = (r_state == ST_RUN) && (cnt_in != w_prev_inc) && (cnt_in != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_err <= 1'b0;
        else if (w_step_err) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign w_step_err = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = w_step_err ? ST_FAULT : ST_RUN;
            ST_FAULT: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    assign w_push    = w_wrap || w_step_err;
    assign w_ev_type = w_step_err ? EV_STEP_ERR : EV_WRAP;
    assign w_ev_word = pack_event(w_ev_type, r_seq, cnt_in);
    assign w_pop     = ev_valid && ev_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_seq      <= '0;
            r_wrap_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_prev <= cnt_in;
            if (w_push_ok)                       r_seq      <= r_seq + SEQ_W'(1);
            if (w_wrap && (r_wrap_cnt != 8'hFF)) r_wrap_cnt <= r_wrap_cnt + 8'd1;
            if (w_push && !w_push_ok)            r_ovf      <= 1'b1;
        end
    end

    cnt_monitor_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_data    (w_ev_word),
        .i_pop     (w_pop),
        .o_push_ok (w_push_ok),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (ev_data)
    );

    assign ev_valid    = !w_empty;
    assign wrap_cnt    = r_wrap_cnt;
    assign ev_overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/cnt_monitor.md
CNT_MONITOR -- requirements
Module: cnt_monitor

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the event-buffer entry count (power of two, 2..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 cnt_in  input  4  SHALL carry the upstream counter value, sampled every clk edge.
REQ-005 ev_valid  output  1  SHALL be high when the buffer head holds an event.
REQ-006 ev_ready  input  1  SHALL indicate the consumer accepts the head event this cycle.
REQ-007 ev_data  output  8  SHALL be the head event: {type[1:0], seq[1:0], value[3:0]}.
REQ-008 wrap_cnt  output  8  SHALL count detected wraps, saturating at 255.
REQ-009 err  output  1  SHALL be a sticky step-error flag.
REQ-010 ev_overflow  output  1  SHALL be a sticky flag for an event dropped on a full buffer.

Function
REQ-011 The FSM SHALL have states INIT, RUN and FAULT.
REQ-012 INIT SHALL capture cnt_in into prev at the first edge after reset release, emit no event, and go to RUN.
REQ-013 In RUN, a legal step SHALL be cnt_in == prev+1 mod 16, or cnt_in == 0 (upstream reset).
REQ-014 A wrap SHALL be prev == 15 and cnt_in == 0; it SHALL increment wrap_cnt and push event type 2'b01.
REQ-015 An illegal step SHALL set err, push event type 2'b10, and move the FSM to FAULT.
REQ-016 FAULT SHALL skip checking for one cycle, recapture prev from cnt_in, and return to RUN.
REQ-017 prev SHALL update from cnt_in every cycle in every state.
REQ-018 Event value SHALL be the cnt_in sampled at the triggering edge.
REQ-019 Event seq SHALL be a 2-bit counter that increments on every accepted push and wraps 3 -> 0.
REQ-020 An event SHALL be written at the detecting edge, with ev_valid high from the next cycle (latency 1) when the buffer was empty.
REQ-021 A pop SHALL occur on an edge where ev_valid and ev_ready are both high; ev_data SHALL be stable while ev_valid is high and ev_ready is low.
REQ-022 A push into a full buffer with no same-edge pop SHALL be dropped, SHALL set ev_overflow, and SHALL leave seq unchanged.
REQ-023 A push with a same-edge pop on a full buffer SHALL be accepted.
REQ-024 A push with a same-edge pop on an empty buffer SHALL be accepted, with ev_valid high next cycle.
REQ-025 err and ev_overflow SHALL clear only on reset.

Reset
REQ-026 On rst_n low, the following SHALL clear immediately: FSM to INIT, prev=0, seq=0, buffer empty, ev_valid=0, ev_data=0, wrap_cnt=0, err=0, ev_overflow=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered events with no partial pop.

Configuration
REQ-028 Macro CNT_MONITOR_STEP_CHECK_EN defined SHALL enable REQ-013/015/016 step checking.
REQ-029 Without CNT_MONITOR_STEP_CHECK_EN, every step SHALL be legal, FAULT SHALL be unreachable, err SHALL be tied to 0, and wrap detection SHALL be unchanged.

Structure
REQ-030 Package cnt_monitor_pkg SHALL hold the FSM state encoding, the event type constants (EV_WRAP=2'b01, EV_STEP_ERR=2'b10), and the ev_data field widths.
REQ-031 The event buffer SHALL be a sub-module cnt_monitor_fifo (synchronous FIFO, push/pop/full/empty) instantiated once.

Verification
REQ-032 Release reset; drive cnt_in 0..15,0 with ev_ready=1 -> one event 8'h40 (type 01, seq 0, value 0); wrap_cnt=1; err=0.
REQ-033 Drive cnt_in 3,4,9 -> event type 10 with value 9; err=1 sticky; the next step 10 produces no event (FAULT resync).
REQ-034 With ev_ready=0, force 5 wraps at FIFO_DEPTH=4 -> 4 events held with seq 0,1,2,3; 5th dropped; ev_overflow=1.
REQ-035 On a full buffer, wrap coincident with ev_ready=1 -> push accepted, occupancy stays 4, ev_overflow stays 0.
REQ-036 Assert rst_n low with 2 events buffered -> ev_valid=0 and all outputs 0 immediately, without waiting for clk.
REQ-037 With CNT_MONITOR_STEP_CHECK_EN undefined, drive 3,4,9 -> no event and err=0; a 15 -> 0 wrap still increments wrap_cnt.
